// File: rtl/fifo_sync_flags.sv
`default_nettype none
//============================================================================
// Module   : fifo_sync_flags
// Brief    : Single-clock FIFO with wrap-bit pointers, occupancy count,
//            almost-full/almost-empty, sticky overflow/underflow and flush.
//            Define FIFO_FWFT_EN for first-word fall-through read data.
// Revision : 1.0 - initial release
//============================================================================
module fifo_sync_flags #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 8,
    parameter  int AF_LEVEL   = 6,
    parameter  int AE_LEVEL   = 2,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_W:0] c_af_level = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ae_level = AE_LEVEL[ADDR_W:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]       r_wptr;
    logic [ADDR_W:0]       r_rptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_W-1:0]     w_waddr;
    logic [ADDR_W-1:0]     w_raddr;

    assign w_waddr = r_wptr[ADDR_W-1:0];
    assign w_raddr = r_rptr[ADDR_W-1:0];

    // Status decoded purely from registered pointers.
    assign empty        = (r_wptr == r_rptr);
    assign full         = (w_waddr == w_raddr) && (r_wptr[ADDR_W] != r_rptr[ADDR_W]);
    assign count        = r_wptr - r_rptr;
    assign almost_full  = (count >= c_af_level);
    assign almost_empty = (count <= c_ae_level);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Flush wins over both requests in the same cycle.
    assign w_wr_acc = w_en && !full  && !clr;
    assign w_rd_acc = r_en && !empty && !clr;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_waddr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_en && full) begin
                r_overflow <= 1'b1;
            end
            if (r_en && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : r_mem[w_raddr];
`else
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= r_mem[w_raddr];
        end
    end

    assign data_out = r_dout;
`endif

endmodule
`default_nettype wire
